key_debouncer: RTL and testbench

Four-channel push-button/switch conditioner that sits directly upstream of the LED/blink control logic on the 50 MHz Cyclone board. It synchronises raw, asynchronous, bouncing key inputs into the `clk` domain, filters them with a per-channel stability counter, and drives clean debounced levels onto the downstream `P[3:0]` bus. It also emits one-cycle press and release strobes. Keys are active-low: 0 means pressed, 1 means released.

---
 rtl/key_debouncer.sv | 80 ++++++++
 tb/tb_key_debouncer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// key_debouncer: four-channel key conditioner. It synchronises raw active-low
// keys, qualifies them with a per-channel stability counter, and produces
// clean levels plus one-cycle press/release strobes. All outputs are driven
// straight from flops.
// The release strobe port is named released because release is a
// SystemVerilog keyword.
module key_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_out,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] released
);

    // Terminal count: the cycle on which a differing level is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Next-state logic: two-flop synchroniser, then a per-channel stability
    // counter that clears whenever s2 agrees with the accepted level.
    always_comb begin
        s1_d      = key_raw;
        s2_d      = s1_q;
        key_d     = key_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != key_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    key_d[i]     = s2_q[i];
                    press_d[i]   = ~s2_q[i];
                    release_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State registers; reset discards any partial count and reports all keys released.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '1;
            s2_q      <= '1;
            key_q     <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_out  = key_q;
    assign press    = press_q;
    assign released = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed stimulus with a scoreboard of expected strobe
// events; a negedge monitor pops and compares each strobe the DUT presents.
module tb_key_debouncer;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = 3;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] k;
    } ev_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] key_raw = 4'b0000;
    logic [3:0] key_out;
    logic [3:0] press;
    logic [3:0] released;

    int  cyc     = 0;
    int  vectors = 0;
    int  errors  = 0;
    ev_t sb[$];

    key_debouncer #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_raw(key_raw),
        .key_out(key_out),
        .press(press),
        .released(released)
    );

    // Free-running clock and posedge counter used to timestamp events.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe the DUT shows must match the oldest expected event.
    always @(negedge clk) begin
        if ((press | released) !== 4'b0000) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe at cyc %0d: press=%b release=%b key_out=%b, required none",
                         cyc, press, released, key_out);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || press !== e.p || released !== e.r || key_out !== e.k) begin
                    errors++;
                    $display("[TB] FAIL strobe_event got cyc=%0d press=%b release=%b key_out=%b, required cyc=%0d press=%b release=%b key_out=%b",
                             cyc, press, released, key_out, e.cyc, e.p, e.r, e.k);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] raw);
        key_raw = raw;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectEvent(input int delay, input logic [3:0] p, input logic [3:0] r,
                               input logic [3:0] k);
        ev_t e;
        e.cyc = cyc + delay;
        e.p   = p;
        e.r   = r;
        e.k   = k;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_key);
        vectors++;
        if (key_out !== exp_key) begin
            errors++;
            $display("[TB] FAIL %s key_out: got %b, required %b", name, key_out, exp_key);
        end
        vectors++;
        if (press !== 4'b0000 || released !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL %s strobes: got press=%b release=%b, required 0000/0000",
                     name, press, released);
        end
    endtask

    initial begin
        // Scenario 1: reset held for 3 cycles with all keys low.
        rst = 1'b1;
        applyStimulus(4'b0000);
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_state", 4'b1111);
        end
        rst = 1'b0;
        expectEvent(6, 4'b1111, 4'b0000, 4'b0000);
        waitCycles(10);
        checkOutput("all_pressed", 4'b0000);
        applyStimulus(4'b1111);
        expectEvent(6, 4'b0000, 4'b1111, 4'b1111);
        waitCycles(10);

        // Scenario 2: clean press and release on ch0.
        applyStimulus(4'b1110);
        expectEvent(6, 4'b0001, 4'b0000, 4'b1110);
        waitCycles(10);
        checkOutput("ch0_held", 4'b1110);
        applyStimulus(4'b1111);
        expectEvent(6, 4'b0000, 4'b0001, 4'b1111);
        waitCycles(10);

        // Scenario 3: ch1 bounces with excursions one cycle too short.
        applyStimulus(4'b1101);
        waitCycles(3);
        applyStimulus(4'b1111);
        waitCycles(1);
        applyStimulus(4'b1101);
        waitCycles(3);
        applyStimulus(4'b1111);
        waitCycles(10);
        checkOutput("ch1_bounce_rejected", 4'b1111);

        // Scenario 4: ch2 bounces 0,0,1 then settles low.
        applyStimulus(4'b1011);
        waitCycles(2);
        applyStimulus(4'b1111);
        waitCycles(1);
        applyStimulus(4'b1011);
        expectEvent(6, 4'b0100, 4'b0000, 4'b1011);
        waitCycles(10);
        checkOutput("ch2_settled", 4'b1011);
        applyStimulus(4'b1111);
        expectEvent(6, 4'b0000, 4'b0100, 4'b1111);
        waitCycles(10);

        // Scenario 5: ch0 and ch3 together, ch1 two cycles later.
        applyStimulus(4'b0110);
        expectEvent(6, 4'b1001, 4'b0000, 4'b0110);
        waitCycles(2);
        applyStimulus(4'b0100);
        expectEvent(6, 4'b0010, 4'b0000, 4'b0100);
        waitCycles(10);
        checkOutput("multi_held", 4'b0100);
        applyStimulus(4'b1111);
        expectEvent(6, 4'b0000, 4'b1011, 4'b1111);
        waitCycles(10);

        // Scenario 6: reset lands on the cycle ch2 would have been accepted.
        applyStimulus(4'b1011);
        waitCycles(5);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("reset_mid_count", 4'b1111);
        rst = 1'b0;
        expectEvent(6, 4'b0100, 4'b0000, 4'b1011);
        waitCycles(10);
        checkOutput("ch2_after_reset", 4'b1011);
        applyStimulus(4'b1111);
        expectEvent(6, 4'b0000, 4'b0100, 4'b1111);
        waitCycles(10);
        checkOutput("final_idle", 4'b1111);

        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_events: %0d still pending, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
